// File: rtl/pic_pkg.sv
// ----------------------------------------------------------------------------
// pic_pkg
// Shared constants and types for the PIC request/priority path.
//   NUM_IR      number of interrupt request lines
//   ir_vec_t    one bit per request line
//   LTIM_LEVEL  ICW1 LTIM value selecting level-triggered requests
//   LTIM_EDGE   ICW1 LTIM value selecting edge-triggered requests
// ----------------------------------------------------------------------------
package pic_pkg;

    localparam int unsigned NUM_IR = 8;

    typedef logic [NUM_IR-1:0] ir_vec_t;

    localparam logic LTIM_LEVEL = 1'b1;
    localparam logic LTIM_EDGE  = 1'b0;

endpackage

// File: rtl/ir_sync_edge.sv
// ----------------------------------------------------------------------------
// ir_sync_edge
// Conditions the external IR lines: brings them into the clk domain and
// produces the sampled level s and a one-cycle rising-edge flag rise.
//
// Build option (macro IR_SYNC_EN):
//   defined   - each line passes a 2-flop synchroniser before s
//   undefined - each line is registered once (inputs already synchronous)
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   ir     in   raw request lines
//   s      out  conditioned request level
//   rise   out  s & ~s_prev, suppressed until s_prev holds a post-reset sample
// ----------------------------------------------------------------------------
module ir_sync_edge #(
    parameter int unsigned NUM_IR = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_IR-1:0] ir,
    output logic [NUM_IR-1:0] s,
    output logic [NUM_IR-1:0] rise
);

    logic [NUM_IR-1:0] s_q;
    logic [NUM_IR-1:0] s_prev_q;

`ifdef IR_SYNC_EN
    localparam int unsigned SyncStages = 2;

    logic [NUM_IR-1:0] meta_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            s_q    <= '0;
        end else begin
            meta_q <= ir;
            s_q    <= meta_q;
        end
    end
`else
    localparam int unsigned SyncStages = 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q <= '0;
        end else begin
            s_q <= ir;
        end
    end
`endif

    // Tracks which pipeline stages hold real post-reset samples. The reset
    // zeros in s_prev are not a genuine "low", so a line already high when
    // reset releases must not look like a rising edge.
    logic [SyncStages:0] vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_prev_q <= '0;
            vld_q    <= '0;
        end else begin
            s_prev_q <= s_q;
            vld_q    <= {vld_q[SyncStages-1:0], 1'b1};
        end
    end

    assign s    = s_q;
    assign rise = s_q & ~s_prev_q & {NUM_IR{vld_q[SyncStages]}};

endmodule

// File: rtl/interrupt_request_register.sv
// ----------------------------------------------------------------------------
// interrupt_request_register
// Captures IR lines into the IRR (edge or level triggered), applies the IMR
// and presents masked pending requests plus a registered summary request.
//
// Build option (macro IR_SYNC_EN): adds a 2-flop input synchroniser, making
// ir -> irr/int_req latency 3 clk edges instead of 2.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   ir         in   external request lines
//   ltim       in   1 = level triggered, 0 = edge triggered
//   imr_wr     in   strobe: load imr from imr_wdata
//   imr_wdata  in   new mask value
//   ack_valid  in   strobe: clear IRR bits selected by ack_vec
//   ack_vec    in   bits to clear
//   irr_raw    out  unmasked IRR
//   irr        out  irr_raw & ~imr
//   imr        out  current mask
//   int_req    out  registered |irr, cycle-aligned with irr
// ----------------------------------------------------------------------------
module interrupt_request_register #(
    parameter int unsigned       NUM_IR  = pic_pkg::NUM_IR,
    parameter logic [NUM_IR-1:0] IMR_RST = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_IR-1:0] ir,
    input  logic              ltim,
    input  logic              imr_wr,
    input  logic [NUM_IR-1:0] imr_wdata,
    input  logic              ack_valid,
    input  logic [NUM_IR-1:0] ack_vec,
    output logic [NUM_IR-1:0] irr_raw,
    output logic [NUM_IR-1:0] irr,
    output logic [NUM_IR-1:0] imr,
    output logic              int_req
);

    import pic_pkg::*;

    logic [NUM_IR-1:0] s;
    logic [NUM_IR-1:0] rise;
    logic [NUM_IR-1:0] set_req;
    logic [NUM_IR-1:0] ack_clr;

    logic [NUM_IR-1:0] irr_d, irr_q;
    logic [NUM_IR-1:0] imr_d, imr_q;
    logic              int_req_d, int_req_q;

    ir_sync_edge #(
        .NUM_IR (NUM_IR)
    ) u_ir_sync_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .ir    (ir),
        .s     (s),
        .rise  (rise)
    );

    always_comb begin
        set_req   = (ltim == LTIM_LEVEL) ? s : rise;
        ack_clr   = ack_valid ? ack_vec : '0;
        // Ack beats everything; a low line drops the request; otherwise set or hold.
        irr_d     = (irr_q | set_req) & s & ~ack_clr;
        imr_d     = imr_wr ? imr_wdata : imr_q;
        // Built from next-state values so int_req lines up with irr.
        int_req_d = |(irr_d & ~imr_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irr_q     <= '0;
            imr_q     <= IMR_RST;
            int_req_q <= 1'b0;
        end else begin
            irr_q     <= irr_d;
            imr_q     <= imr_d;
            int_req_q <= int_req_d;
        end
    end

    assign irr_raw = irr_q;
    assign irr     = irr_q & ~imr_q;
    assign imr     = imr_q;
    assign int_req = int_req_q;

endmodule

// File: tb/tb_interrupt_request_register.sv
module tb_interrupt_request_register;
    import pic_pkg::*;

`ifdef IR_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam ir_vec_t IMR_RST = 8'h00;

    logic    clk = 1'b0;
    logic    rst_n;
    ir_vec_t ir, imr_wdata, ack_vec;
    logic    ltim, imr_wr, ack_valid;
    ir_vec_t irr_raw, irr, imr;
    logic    int_req;

    interrupt_request_register #(
        .NUM_IR  (NUM_IR),
        .IMR_RST (IMR_RST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ir        (ir),
        .ltim      (ltim),
        .imr_wr    (imr_wr),
        .imr_wdata (imr_wdata),
        .ack_valid (ack_valid),
        .ack_vec   (ack_vec),
        .irr_raw   (irr_raw),
        .irr       (irr),
        .imr       (imr),
        .int_req   (int_req)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a history of ir samples taken at each clk edge since
    // reset; the conditioned level is the sample from LAT edges ago.
    ir_vec_t hist[$];
    int      m_edges;
    ir_vec_t m_irr, m_imr;
    logic    m_int;

    task automatic model_reset();
        hist.delete();
        m_edges = 0;
        m_irr   = '0;
        m_imr   = IMR_RST;
        m_int   = 1'b0;
    endtask

    task automatic model_step();
        ir_vec_t lvl, prev, nxt;
        logic    prev_ok;
        lvl     = (m_edges >= LAT) ? hist[LAT-1] : '0;
        prev_ok = (m_edges >= LAT + 1);
        prev    = prev_ok ? hist[LAT] : '0;
        for (int i = 0; i < NUM_IR; i++) begin
            if (ack_valid && ack_vec[i])      nxt[i] = 1'b0;
            else if (!lvl[i])                 nxt[i] = 1'b0;
            else if (ltim)                    nxt[i] = 1'b1;
            else if (prev_ok && !prev[i])     nxt[i] = 1'b1;
            else                              nxt[i] = m_irr[i];
        end
        if (imr_wr) m_imr = imr_wdata;
        m_irr = nxt;
        m_int = (m_irr & ~m_imr) != '0;
        hist.push_front(ir);
        while (hist.size() > LAT + 1) void'(hist.pop_back());
        if (m_edges < 100) m_edges++;
    endtask

    task automatic expect_val(input string name, input ir_vec_t act, input ir_vec_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        expect_val({tag, ".irr_raw"}, irr_raw, m_irr);
        expect_val({tag, ".irr"}, irr, m_irr & ~m_imr);
        expect_val({tag, ".imr"}, imr, m_imr);
        expect_val({tag, ".int_req"}, {7'd0, int_req}, {7'd0, m_int});
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        check_model(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int k = 0; k < n; k++) cycle(tag);
    endtask

    task automatic pulse_reset();
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        expect_val("async_rst.irr_raw", irr_raw, 8'h00);
        expect_val("async_rst.irr", irr, 8'h00);
        expect_val("async_rst.imr", imr, IMR_RST);
        expect_val("async_rst.int_req", {7'd0, int_req}, 8'h00);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        ir_vec_t ir;
        logic    ltim;
        logic    imr_wr;
        ir_vec_t imr_wdata;
        logic    ack_valid;
        ir_vec_t ack_vec;
        ir_vec_t exp_raw;
        ir_vec_t exp_irr;
        logic    exp_int;
    } vec_t;

    vec_t tbl[12];

    initial begin
        // ir, ltim, imr_wr, wdata, ack_valid, ack_vec, raw, irr, int
        tbl[0]  = '{8'h00, 1'b1, 1'b1, 8'h81, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[1]  = '{8'h81, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h81, 8'h00, 1'b0};
        tbl[2]  = '{8'h81, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 8'h81, 8'h81, 1'b1};
        tbl[3]  = '{8'h81, 1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 8'h81, 8'h81, 1'b1};
        tbl[4]  = '{8'h80, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h80, 8'h80, 1'b1};
        tbl[5]  = '{8'h80, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h80, 8'h80, 1'b1};
        tbl[6]  = '{8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 8'h80, 8'h00, 8'h00, 1'b0};
        tbl[7]  = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[8]  = '{8'h24, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h24, 8'h24, 1'b1};
        tbl[9]  = '{8'h24, 1'b0, 1'b1, 8'h20, 1'b0, 8'h00, 8'h24, 8'h04, 1'b1};
        tbl[10] = '{8'h24, 1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 8'h20, 8'h00, 1'b0};
        tbl[11] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};

        rst_n = 1'b0; ir = '0; ltim = 1'b0; imr_wr = 1'b0; imr_wdata = '0;
        ack_valid = 1'b0; ack_vec = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        expect_val("reset.irr_raw", irr_raw, 8'h00);
        expect_val("reset.imr", imr, IMR_RST);
        expect_val("reset.int_req", {7'd0, int_req}, 8'h00);
        rst_n = 1'b1;
        run(3, "idle");

        // Table: apply strobes for one cycle, hold levels until settled.
        for (int r = 0; r < 12; r++) begin
            ir = tbl[r].ir; ltim = tbl[r].ltim; imr_wr = tbl[r].imr_wr;
            imr_wdata = tbl[r].imr_wdata; ack_valid = tbl[r].ack_valid;
            ack_vec = tbl[r].ack_vec;
            cycle($sformatf("row%0d", r));
            imr_wr = 1'b0; ack_valid = 1'b0;
            run(LAT + 1, $sformatf("row%0d", r));
            expect_val($sformatf("row%0d.irr_raw", r), irr_raw, tbl[r].exp_raw);
            expect_val($sformatf("row%0d.irr", r), irr, tbl[r].exp_irr);
            expect_val($sformatf("row%0d.int_req", r), {7'd0, int_req}, {7'd0, tbl[r].exp_int});
        end

        // Edge mode: exact latency, ack while high, re-arm on fresh edge.
        ltim = LTIM_EDGE; ir = 8'h04;
        run(LAT, "edge_lat");
        expect_val("edge_lat.early", irr, 8'h00);
        cycle("edge_lat");
        expect_val("edge_lat.irr", irr, 8'h04);
        expect_val("edge_lat.int_req", {7'd0, int_req}, 8'h01);
        ack_valid = 1'b1; ack_vec = 8'h04;
        cycle("edge_ack");
        ack_valid = 1'b0;
        expect_val("edge_ack.irr", irr, 8'h00);
        run(4, "edge_hold");
        expect_val("edge_hold.irr", irr, 8'h00);
        ir = 8'h00; run(LAT + 1, "edge_drop");
        ir = 8'h04; run(LAT + 1, "edge_rearm");
        expect_val("edge_rearm.irr", irr, 8'h04);
        ir = 8'h00; run(LAT + 1, "edge_clr");

        // Level mode: ack clears for one cycle only while the line stays high.
        ltim = LTIM_LEVEL; ir = 8'h20;
        run(LAT + 1, "lvl");
        expect_val("lvl.irr", irr, 8'h20);
        ack_valid = 1'b1; ack_vec = 8'h20;
        cycle("lvl_ack");
        ack_valid = 1'b0;
        expect_val("lvl_ack.irr", irr, 8'h00);
        cycle("lvl_reset");
        expect_val("lvl_reset.irr", irr, 8'h20);
        ir = 8'h00; run(LAT + 1, "lvl_drop");
        expect_val("lvl_drop.irr", irr, 8'h00);

        // Edge pulse lost before ack.
        ltim = LTIM_EDGE; ir = 8'h08;
        run(5, "pulse");
        expect_val("pulse.irr", irr, 8'h08);
        ir = 8'h00; run(LAT + 1, "pulse_lost");
        expect_val("pulse_lost.irr_raw", irr_raw, 8'h00);
        expect_val("pulse_lost.int_req", {7'd0, int_req}, 8'h00);

        // Ack coinciding with the rising edge wins.
        ir = 8'h02; run(LAT, "conflict");
        ack_valid = 1'b1; ack_vec = 8'h02;
        cycle("conflict_ack");
        ack_valid = 1'b0;
        expect_val("conflict.irr_raw", irr_raw, 8'h00);
        run(3, "conflict_hold");
        expect_val("conflict_hold.irr_raw", irr_raw, 8'h00);
        ir = 8'h00; run(LAT + 1, "conflict_drop");
        ir = 8'h02; run(LAT + 1, "conflict_rearm");
        expect_val("conflict_rearm.irr", irr, 8'h02);

        // Reset mid-request with all lines high.
        ltim = LTIM_LEVEL; ir = 8'hFF; imr_wr = 1'b1; imr_wdata = 8'h5A;
        cycle("pre_rst");
        imr_wr = 1'b0;
        run(LAT + 1, "pre_rst");
        expect_val("pre_rst.irr_raw", irr_raw, 8'hFF);
        ltim = LTIM_EDGE;
        pulse_reset();
        run(6, "post_rst_edge");
        expect_val("post_rst_edge.irr_raw", irr_raw, 8'h00);
        ltim = LTIM_LEVEL;
        pulse_reset();
        run(LAT, "post_rst_lvl");
        expect_val("post_rst_lvl.early", irr_raw, 8'h00);
        cycle("post_rst_lvl");
        expect_val("post_rst_lvl.irr", irr, 8'hFF);

        // Randomised traffic against the model.
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 15) == 0) ltim = ~ltim;
            for (int b = 0; b < NUM_IR; b++)
                if ($urandom_range(0, 5) == 0) ir[b] = ~ir[b];
            imr_wr    = ($urandom_range(0, 9) == 0);
            imr_wdata = ir_vec_t'($urandom);
            ack_valid = ($urandom_range(0, 3) == 0);
            ack_vec   = ir_vec_t'($urandom);
            cycle("rand");
        end
        imr_wr = 1'b0; ack_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
